// File: rtl/answer_judge.sv
// rtl/answer_judge.sv - memory-game round controller: shows a 4-symbol LFSR sequence, then judges button presses.
module answer_judge #(
  parameter int SHOW_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [1:0] target_sym,
  output logic       show_valid,
  output logic       busy,
  output logic [2:0] step,
  output logic       is_correct,
  output logic       is_wrong
);

  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_INPUT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    seq_q, seq_d;
  logic [3:0]    btn_q;
  logic [2:0]    step_q, step_d;
  logic [1:0]    sym_idx_q, sym_idx_d;
  logic [SW-1:0] show_cnt_q, show_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    target_sym_q, target_sym_d;
  logic          show_valid_q, show_valid_d;
  logic          busy_q, busy_d;
  logic          is_correct_q, is_correct_d;
  logic          is_wrong_q, is_wrong_d;

  logic       press;
  logic       press_ok;
  logic [1:0] expect_sym;

  // A press is a rising edge of "any button down"; a held button never re-triggers.
  assign press      = (btn != 4'b0000) && (btn_q == 4'b0000);
  assign expect_sym = seq_q[{step_q[1:0], 1'b0} +: 2];
  assign press_ok   = (btn == (4'b0001 << expect_sym));

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    step_d       = step_q;
    sym_idx_d    = sym_idx_q;
    show_cnt_d   = show_cnt_q;
    timer_d      = timer_q;
    is_correct_d = 1'b0;
    is_wrong_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHOW;
          seq_d      = lfsr_q;
          step_d     = 3'd0;
          sym_idx_d  = 2'd0;
          show_cnt_d = '0;
          timer_d    = '0;
        end
      end
      ST_SHOW: begin
        if (show_cnt_q == SHOW_LAST) begin
          show_cnt_d = '0;
          if (sym_idx_q == 2'd3) begin
            state_d = ST_INPUT;
            timer_d = '0;
          end else begin
            sym_idx_d = sym_idx_q + 2'd1;
          end
        end else begin
          show_cnt_d = show_cnt_q + SW'(1);
        end
      end
      ST_INPUT: begin
        // A press on the expiry cycle is judged normally and beats the timeout.
        if (press) begin
          if (press_ok) begin
            step_d  = step_q + 3'd1;
            timer_d = '0;
            if (step_q == 3'd3) begin
              state_d      = ST_IDLE;
              is_correct_d = 1'b1;
            end
          end else begin
            state_d    = ST_IDLE;
            is_wrong_d = 1'b1;
          end
        end else if (timer_q == TIME_LAST) begin
          state_d    = ST_IDLE;
          is_wrong_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    show_valid_d = (state_d == ST_SHOW);
    busy_d       = (state_d != ST_IDLE);
    target_sym_d = show_valid_d ? seq_d[{sym_idx_d, 1'b0} +: 2] : 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= 8'hA5;
      seq_q        <= 8'h00;
      btn_q        <= 4'b0000;
      step_q       <= 3'd0;
      sym_idx_q    <= 2'd0;
      show_cnt_q   <= '0;
      timer_q      <= '0;
      target_sym_q <= 2'd0;
      show_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      is_correct_q <= 1'b0;
      is_wrong_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      seq_q        <= seq_d;
      btn_q        <= btn;
      step_q       <= step_d;
      sym_idx_q    <= sym_idx_d;
      show_cnt_q   <= show_cnt_d;
      timer_q      <= timer_d;
      target_sym_q <= target_sym_d;
      show_valid_q <= show_valid_d;
      busy_q       <= busy_d;
      is_correct_q <= is_correct_d;
      is_wrong_q   <= is_wrong_d;
    end
  end

  assign target_sym = target_sym_q;
  assign show_valid = show_valid_q;
  assign busy       = busy_q;
  assign step       = step_q;
  assign is_correct = is_correct_q;
  assign is_wrong   = is_wrong_q;

endmodule

// File: tb/tb_answer_judge.sv
// tb/tb_answer_judge.sv - self-checking bench for answer_judge against a cycle-timestamp round model.
module tb_answer_judge;

  localparam int S = 4;
  localparam int T = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic [1:0] target_sym;
  logic       show_valid;
  logic       busy;
  logic [2:0] step;
  logic       is_correct;
  logic       is_wrong;

  int   n_checks = 0;
  int   n_errors = 0;
  int   score    = 0;
  bit   chk_en   = 1'b0;
  logic last_cor = 1'b0;
  logic last_wrong = 1'b0;

  answer_judge #(.SHOW_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn),
    .target_sym(target_sym), .show_valid(show_valid), .busy(busy),
    .step(step), .is_correct(is_correct), .is_wrong(is_wrong)
  );

  always #5 clk = ~clk;

  // Round model: modes 0 idle, 1 show, 2 input; timing kept as absolute edge numbers.
  typedef struct {
    int         mode;
    int         cyc;
    int         t0;
    int         tref;
    logic [7:0] lfsr;
    logic [7:0] seq;
    int         stp;
    logic [3:0] prev;
    bit         cor;
    bit         wrong;
  } model_t;

  model_t ms;

  function automatic int sym_of(input logic [7:0] s, input int k);
    logic [7:0] sh;
    sh = s >> (2 * k);
    return int'(sh & 8'h03);
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.mode = 0; m.cyc = 0; m.t0 = 0; m.tref = 0;
    m.lfsr = 8'hA5; m.seq = 8'h00; m.stp = 0; m.prev = 4'b0000;
    m.cor = 1'b0; m.wrong = 1'b0;
    return m;
  endfunction

  function automatic model_t model_next(input model_t m, input logic st, input logic [3:0] b);
    model_t n = m;
    n.cyc   = m.cyc + 1;
    n.cor   = 1'b0;
    n.wrong = 1'b0;
    if (m.mode == 0) begin
      if (st) begin
        n.mode = 1; n.t0 = n.cyc; n.seq = m.lfsr; n.stp = 0;
      end
    end else if (m.mode == 1) begin
      if (n.cyc - m.t0 == 4 * S) begin
        n.mode = 2; n.tref = n.cyc;
      end
    end else begin
      if (b != 4'b0000 && m.prev == 4'b0000) begin
        if ($countones(b) == 1 && b[sym_of(m.seq, m.stp)]) begin
          n.stp  = m.stp + 1;
          n.tref = n.cyc;
          if (n.stp == 4) begin
            n.cor = 1'b1; n.mode = 0;
          end
        end else begin
          n.wrong = 1'b1; n.mode = 0;
        end
      end else if (n.cyc - m.tref == T) begin
        n.wrong = 1'b1; n.mode = 0;
      end
    end
    n.prev = b;
    n.lfsr = {m.lfsr[6:0], ^(m.lfsr & 8'hB8)};
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) ms <= model_reset();
    else        ms <= model_next(ms, start, btn);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("show_valid", int'(show_valid), (ms.mode == 1) ? 1 : 0);
      check("busy", int'(busy), (ms.mode != 0) ? 1 : 0);
      check("step", int'(step), ms.stp);
      check("target_sym", int'(target_sym),
            (ms.mode == 1) ? sym_of(ms.seq, (ms.cyc - ms.t0) / S) : 0);
      check("is_correct", int'(is_correct), int'(ms.cor));
      check("is_wrong", int'(is_wrong), int'(ms.wrong));
    end
  end

  always @(negedge clk) begin
    if (is_correct) score <= score + 1;
  end

  task automatic press(input logic [3:0] b);
    btn = b;
    @(negedge clk);
    last_cor   = is_correct;
    last_wrong = is_wrong;
    btn = 4'b0000;
    @(negedge clk);
  endtask

  // Leaves the bench at the first negedge of INPUT.
  task automatic round_any();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4 * S) @(negedge clk);
  endtask

  task automatic round_a5();
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    round_any();
  endtask

  initial begin
    int r;
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_show_valid", int'(show_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(step), 0);
    check("rst_pulses", int'(is_correct) + int'(is_wrong), 0);

    // Correct round on seq A5 -> symbols 1,1,2,2
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_sym0", int'(target_sym), 1);
    check("t1_show0", int'(show_valid), 1);
    repeat (S) @(negedge clk);
    check("t1_sym1", int'(target_sym), 1);
    repeat (S) @(negedge clk);
    check("t1_sym2", int'(target_sym), 2);
    repeat (S) @(negedge clk);
    check("t1_sym3", int'(target_sym), 2);
    repeat (S) @(negedge clk);
    check("t1_input_show", int'(show_valid), 0);
    check("t1_input_busy", int'(busy), 1);
    press(4'b0010); check("t1_step1", int'(step), 1);
    press(4'b0010); check("t1_step2", int'(step), 2);
    press(4'b0100); check("t1_step3", int'(step), 3);
    press(4'b0100);
    check("t1_step4", int'(step), 4);
    check("t1_correct_pulse", int'(last_cor), 1);
    check("t1_busy_end", int'(busy), 0);
    check("t1_score", score, 1);

    // Wrong press
    round_a5();
    press(4'b0010);
    press(4'b1000);
    check("t2_wrong_pulse", int'(last_wrong), 1);
    check("t2_no_correct", int'(last_cor), 0);
    check("t2_step", int'(step), 1);
    check("t2_busy", int'(busy), 0);

    // Multi-bit press, then timeout
    round_any();
    press(4'b0011);
    check("t3_multibit_wrong", int'(last_wrong), 1);
    check("t3_step", int'(step), 0);
    round_any();
    n = 0;
    while (!is_wrong && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t3_timeout_cycles", n, T);
    @(negedge clk);

    // Ignored inputs during SHOW, held button across SHOW->INPUT
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3 * S; k++) begin
      start = 1'($urandom % 2);
      btn   = 4'($urandom % 16);
      @(negedge clk);
    end
    start = 1'b0;
    check("t4_still_show", int'(show_valid), 1);
    check("t4_step_show", int'(step), 0);
    btn = 4'b0001 << sym_of(ms.seq, 0);
    repeat (2 * S) @(negedge clk);
    check("t4_held_no_press", int'(step), 0);
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    press(4'b0001 << sym_of(ms.seq, 0));
    check("t4_repress", int'(step), 1);
    repeat (T + 4) @(negedge clk);

    // Correct press on the exact expiry edge
    round_any();
    repeat (T - 1) @(negedge clk);
    btn = 4'b0001 << sym_of(ms.seq, 0);
    @(negedge clk);
    btn = 4'b0000;
    check("t5_no_wrong", int'(is_wrong), 0);
    check("t5_step", int'(step), 1);
    check("t5_busy", int'(busy), 1);
    repeat (T + 4) @(negedge clk);

    // Asynchronous reset at step 2
    round_a5();
    press(4'b0010);
    press(4'b0010);
    check("t6_step2", int'(step), 2);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_step", int'(step), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_pulses", int'(is_correct) + int'(is_wrong), 0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_lfsr_restart", int'(target_sym), 1);
    repeat (4 * S + T + 4) @(negedge clk);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 6 == 0);
      r = int'($urandom % 10);
      if (r < 4) btn = 4'b0000;
      else if (r < 7) btn = (ms.mode == 2 && ms.stp < 4) ? (4'b0001 << sym_of(ms.seq, ms.stp))
                                                         : 4'($urandom % 16);
      else if (r < 8) btn = 4'($urandom % 16);
      if ($urandom % 400 == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    btn   = 4'b0000;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/answer_judge.md
# answer_judge

Round controller for the button memory game: on `start` it captures a 4-symbol target sequence from a free-running LFSR and presents it one symbol at a time. It then checks the player's button presses against the sequence in order. It ends each round with exactly one single-cycle `is_correct` or `is_wrong` pulse. `is_correct` feeds the score counter's `is_correct` input directly, and `target_sym`/`show_valid` drive the LED display.

## Interface
- `SHOW_CYCLES`, default 50_000_000: cycles each target symbol is displayed (≥1).
- `TIMEOUT_CYCLES`, default 250_000_000: maximum cycles allowed between entering INPUT, or the last correct press, and the next press (≥1).
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a round; sampled only in IDLE.
- `btn`  in  4  synchronized, debounced button levels, one bit per symbol (bit i = symbol i).
- `target_sym`  out  2  symbol currently shown; valid while `show_valid` = 1, otherwise 0.
- `show_valid`  out  1  high during SHOW.
- `busy`  out  1  high in SHOW and INPUT.
- `step`  out  3  number of correct presses so far in this round (0–4).
- `is_correct`  out  1  one-cycle pulse: all 4 symbols entered correctly.
- `is_wrong`  out  1  one-cycle pulse: wrong press or timeout.

## Operation
- **LFSR**
  - 8-bit, shifts left every cycle in all states; `q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}`.
  - Reset value 8'hA5. It never reaches 0.
- **Sequence capture**
  - On an accepted `start`, `seq[7:0]` is loaded with the LFSR value present at that edge, before the shift.
  - Symbol k is `seq[2k+1:2k]`, with k=0 first.
- **Press detection**
  - `btn_q` registers `btn` every cycle in every state.
  - A press occurs when `btn != 0 && btn_q == 0`, evaluated combinationally in the cycle where `btn` first rises.
  - A press with more than one bit set is a wrong press.
  - A press is correct only if it is one-hot and its bit index equals symbol `step`.
  - Buttons held across a state change do not produce a new press.
- **States**
  - IDLE:
    - `start`=1 → SHOW; capture `seq`, clear `step`, clear the timer.
    - Presses are ignored.
  - SHOW:
    - Displays symbol 0..3 for `SHOW_CYCLES` cycles each, tracked by a 2-bit symbol index and a cycle counter.
    - After the last cycle of symbol 3 → INPUT, with the timer cleared.
    - Presses and `start` are ignored.
  - INPUT:
    - Correct press with `step` < 3 → `step`+1, timer cleared, stay in INPUT.
    - Correct press with `step` = 3 → `step` = 4, `is_correct` pulse, go to IDLE.
    - Wrong press → `is_wrong` pulse, go to IDLE; `step` holds its value.
    - No press and timer = `TIMEOUT_CYCLES`-1 → `is_wrong` pulse, go to IDLE.
    - Otherwise the timer increments.
- **Priority:** a press in the same cycle as timer expiry wins, and is judged as correct or wrong normally. `start` in any non-IDLE state is ignored.
- `step` holds its final value in IDLE until the next accepted `start`.
- **Reset, asynchronous, any time:**
  - State = IDLE; LFSR = 8'hA5; `seq`, `btn_q`, `step` and all counters = 0.
  - All outputs = 0.
  - A round in progress is abandoned with no pulse.

## Timing
- All outputs are registered; none is combinational from inputs.
- `start` is sampled at edge E.
  - `show_valid`=1, `busy`=1 and `target_sym`=symbol 0 from E through E+`SHOW_CYCLES`.
  - Symbol k occupies the k-th window of exactly `SHOW_CYCLES` cycles.
  - `show_valid` falls, and INPUT begins, `4*SHOW_CYCLES` cycles after E.
- A press is sampled at edge P.
  - `step` updates at P.
  - `is_correct` or `is_wrong` is high for exactly the cycle after P, and `busy`=0 from P.
- Timeout: `is_wrong` rises `TIMEOUT_CYCLES` cycles after the INPUT-entry or last-correct-press edge.
- Back-to-back rounds: `start` is accepted at the edge after the result pulse edge, or later.
- At most one of `is_correct`/`is_wrong` is high in any cycle, and each round produces at most one pulse.

## Test plan
1. **Correct round:** `SHOW_CYCLES`=4, `TIMEOUT_CYCLES`=16. Release `reset`, assert `start` at the first edge → `seq`=8'hA5, displayed symbols 1,1,2,2 for 4 cycles each. Press `btn`=0010, 0010, 0100, 0100, releasing to 0 between presses → `step` 1,2,3,4, then one `is_correct` pulse; a downstream score counter reads 1.
2. **Wrong press:** same capture as test 1; press 0010, then 1000 → `step`=1 and one `is_wrong` pulse, state IDLE, no `is_correct`.
3. **Multi-bit press and timeout:** press 0011 at `step` 0 → `is_wrong`. New round with no press → `is_wrong` exactly 16 cycles after INPUT entry.
4. **Ignored inputs:** `start` and button presses during SHOW → display timing unchanged, `step` stays 0. A button held from SHOW into INPUT → no press until it is released and pressed again.
5. **Boundary:** a correct press on the exact timer-expiry cycle → judged as a correct press, no `is_wrong`.
6. **Reset mid-INPUT:** pull `reset` low asynchronously at `step`=2 → all outputs 0 immediately, no result pulse; after release, the LFSR restarts from 8'hA5.
